ex_mem_wb_pipe: RTL and testbench

- Holds the EX/MEM and MEM/WB pipeline registers of the 16-bit, 16-register datapath.
- Captures the EX-stage result and control each cycle.
- Runs the MEM-stage handshake with data memory, selects write-back data, and drives the register-file write port.
- Produces the EX/MEM and MEM/WB register-write enables and destination fields consumed by the forwarding unit, and issues a stall to upstream stages while memory is busy.

---
 rtl/ex_mem_wb_pipe.sv | 117 +++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with data-memory handshake and write-back select
module ex_mem_wb_pipe #(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [REG_W-1:0]  ex_dest_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              flush,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall_out,
    output logic              em_reg_write,
    output logic [REG_W-1:0]  em_dest_reg,
    output logic [DATA_W-1:0] em_alu_result,
    output logic              mw_reg_write,
    output logic [REG_W-1:0]  mw_dest_reg,
    output logic [DATA_W-1:0] mw_wb_data,
    output logic              mem_timeout
);
    logic              em_valid_q, em_valid_d;
    logic              em_rw_q, em_rw_d;
    logic              em_m2r_q, em_m2r_d;
    logic              em_mr_q, em_mr_d;
    logic              em_mw_q, em_mw_d;
    logic [REG_W-1:0]  em_dest_q, em_dest_d;
    logic [DATA_W-1:0] em_alu_q, em_alu_d;
    logic [DATA_W-1:0] em_sd_q, em_sd_d;
    logic              flush_pending_q, flush_pending_d;
    logic              mw_valid_q, mw_valid_d;
    logic              mw_rw_q, mw_rw_d;
    logic [REG_W-1:0]  mw_dest_q, mw_dest_d;
    logic [DATA_W-1:0] mw_data_q, mw_data_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    assign mem_req       = em_valid_q & (em_mr_q | em_mw_q);
    assign stall_out     = mem_req & ~mem_ready;
    assign mem_we        = em_valid_q & em_mw_q;
    assign mem_addr      = em_alu_q;
    assign mem_wdata     = em_sd_q;
    assign em_reg_write  = em_valid_q & em_rw_q & (em_dest_q != '0);
    assign em_dest_reg   = em_dest_q;
    assign em_alu_result = em_alu_q;
    assign mw_reg_write  = mw_valid_q & mw_rw_q & (mw_dest_q != '0);
    assign mw_dest_reg   = mw_dest_q;
    assign mw_wb_data    = mw_data_q;
    assign mem_timeout   = timeout_q;

    // Next state: both stages freeze on a stall, MEM/WB emits a bubble, a flush seen mid-stall kills the next capture
    always_comb begin
        em_valid_d      = stall_out ? em_valid_q : ex_valid & ~flush & ~flush_pending_q;
        em_rw_d         = stall_out ? em_rw_q : ex_reg_write;
        em_m2r_d        = stall_out ? em_m2r_q : ex_mem_to_reg;
        em_mr_d         = stall_out ? em_mr_q : ex_mem_read;
        em_mw_d         = stall_out ? em_mw_q : ex_mem_write;
        em_dest_d       = stall_out ? em_dest_q : ex_dest_reg;
        em_alu_d        = stall_out ? em_alu_q : ex_alu_result;
        em_sd_d         = stall_out ? em_sd_q : ex_store_data;
        flush_pending_d = stall_out & (flush_pending_q | flush);
        mw_valid_d      = ~stall_out & em_valid_q;
        mw_rw_d         = stall_out ? mw_rw_q : em_rw_q;
        mw_dest_d       = stall_out ? mw_dest_q : em_dest_q;
        mw_data_d       = stall_out ? mw_data_q : (em_m2r_q ? mem_rdata : em_alu_q);
        wait_cnt_d      = ~stall_out ? 8'd0 : (wait_cnt_q == 8'hFF ? wait_cnt_q : wait_cnt_q + 8'd1);
        timeout_d       = timeout_q | (stall_out & (wait_cnt_q == 8'(MAX_WAIT)));
    end

    // State registers with synchronous active-low reset clearing everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            em_valid_q      <= 1'b0;
            em_rw_q         <= 1'b0;
            em_m2r_q        <= 1'b0;
            em_mr_q         <= 1'b0;
            em_mw_q         <= 1'b0;
            em_dest_q       <= '0;
            em_alu_q        <= '0;
            em_sd_q         <= '0;
            flush_pending_q <= 1'b0;
            mw_valid_q      <= 1'b0;
            mw_rw_q         <= 1'b0;
            mw_dest_q       <= '0;
            mw_data_q       <= '0;
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
        end else begin
            em_valid_q      <= em_valid_d;
            em_rw_q         <= em_rw_d;
            em_m2r_q        <= em_m2r_d;
            em_mr_q         <= em_mr_d;
            em_mw_q         <= em_mw_d;
            em_dest_q       <= em_dest_d;
            em_alu_q        <= em_alu_d;
            em_sd_q         <= em_sd_d;
            flush_pending_q <= flush_pending_d;
            mw_valid_q      <= mw_valid_d;
            mw_rw_q         <= mw_rw_d;
            mw_dest_q       <= mw_dest_d;
            mw_data_q       <= mw_data_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_q       <= timeout_d;
        end
    end
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed and random stimulus against a transaction-level scoreboard of register writes and memory accesses
module tb_ex_mem_wb_pipe;
    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0, flush = 1'b0, mem_ready = 1'b0;
    logic [3:0]  ex_dest_reg = '0;
    logic [15:0] ex_alu_result = '0, ex_store_data = '0, mem_rdata;
    logic        mem_req, mem_we, stall_out, em_reg_write, mw_reg_write, mem_timeout;
    logic [15:0] mem_addr, mem_wdata, em_alu_result, mw_wb_data;
    logic [3:0]  em_dest_reg, mw_dest_reg;

    ex_mem_wb_pipe #(.DATA_W(16), .REG_W(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_dest_reg(ex_dest_reg), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .flush(flush), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_out(stall_out),
        .em_reg_write(em_reg_write), .em_dest_reg(em_dest_reg), .em_alu_result(em_alu_result),
        .mw_reg_write(mw_reg_write), .mw_dest_reg(mw_dest_reg), .mw_wb_data(mw_wb_data),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address; 0x0040 reads back 0x1234
    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'h1274;
    endfunction
    assign mem_rdata = memf(mem_addr);

    logic [19:0] wq[$];
    logic [32:0] mq[$];
    int total = 0, bad = 0, scnt = 0, stall_obs = 0, s0;
    logic busy = 1'b0, fpend = 1'b0, stall_m = 1'b0, to_m = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_mem"}, {29'd0, mem_req, mem_we, mem_addr, mem_wdata, stall_out}, 64'd0);
        chk({n, "_fwd"}, {21'd0, em_reg_write, em_dest_reg, em_alu_result, mw_reg_write, mw_dest_reg, mw_wb_data, mem_timeout}, 64'd0);
    endtask

    // One clock of stimulus; the model advances by instruction-level rules at the edge
    task automatic cyc(input logic v, rw, m2r, mr, mw, input logic [3:0] d,
                       input logic [15:0] alu, sd, input logic fl, rdy);
        logic kill;
        ex_valid = v; ex_reg_write = rw; ex_mem_to_reg = m2r; ex_mem_read = mr; ex_mem_write = mw;
        ex_dest_reg = d; ex_alu_result = alu; ex_store_data = sd; flush = fl; mem_ready = rdy;
        stall_m = busy & ~rdy;
        @(posedge clk);
        if (!rst_n) begin
            wq.delete(); mq.delete();
            busy = 1'b0; fpend = 1'b0; scnt = 0; to_m = 1'b0;
        end else if (stall_m) begin
            fpend = fpend | fl;
            scnt++;
            if (scnt == MW + 1) to_m = 1'b1;
        end else begin
            kill = fl | fpend;
            fpend = 1'b0;
            scnt = 0;
            busy = v & ~kill & (mr | mw);
            if (v & ~kill) begin
                if (rw && d != 4'd0) wq.push_back({d, m2r ? memf(alu) : alu});
                if (mr | mw) mq.push_back({mw, alu, sd});
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, rdy);
    endtask

    // Monitor: checks stall/timeout each cycle and pops the scoreboard on every write-back and memory completion
    always @(negedge clk) begin
        logic [19:0] ew;
        logic [32:0] em;
        chk("stall", {63'd0, stall_out}, {63'd0, stall_m});
        chk("timeout", {63'd0, mem_timeout}, {63'd0, to_m});
        if (stall_out) stall_obs++;
        if (mw_reg_write) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_unexpected: got dest=%0h data=%0h want none", mw_dest_reg, mw_wb_data);
            end else begin
                ew = wq.pop_front();
                chk("wb", {44'd0, mw_dest_reg, mw_wb_data}, {44'd0, ew});
            end
        end
        if (mem_req && mem_ready) begin
            if (mq.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_unexpected: got addr=%0h want none", mem_addr);
            end else begin
                em = mq.pop_front();
                chk("mem", {31'd0, mem_we, mem_addr, mem_wdata}, {31'd0, em});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v, rw, m2r, mr, mw, fl, rdy;
        int op;
        rst_n = 1'b0;
        idle(1'b1);
        idle(1'b1);
        chk_zero("reset");
        rst_n = 1'b1;
        // ALU pass-through
        cyc(1, 1, 0, 0, 0, 4'd1, 16'h00AA, 16'd0, 0, 1);
        chk("t1_em", {59'd0, em_reg_write, em_dest_reg}, {59'd0, 1'b1, 4'd1});
        idle(1'b1);
        chk("t1_mw", {47'd0, mw_reg_write, mw_wb_data}, {47'd0, 1'b1, 16'h00AA});
        // Load with three wait cycles and a flush during the stall
        cyc(1, 1, 1, 1, 0, 4'd2, 16'h0040, 16'd0, 0, 1);
        s0 = stall_obs;
        cyc(1, 1, 0, 0, 0, 4'd3, 16'h0011, 16'd0, 0, 0);
        chk("t2_bubble1", {63'd0, mw_reg_write}, 64'd0);
        cyc(1, 1, 0, 0, 0, 4'd3, 16'h0011, 16'd0, 1, 0);
        chk("t2_bubble2", {63'd0, mw_reg_write}, 64'd0);
        cyc(1, 1, 0, 0, 0, 4'd3, 16'h0011, 16'd0, 0, 0);
        cyc(1, 1, 0, 0, 0, 4'd5, 16'h0055, 16'd0, 0, 1);
        chk("t2_stalls", 64'(stall_obs - s0), 64'd3);
        chk("t2_wb", {43'd0, mw_reg_write, mw_dest_reg, mw_wb_data}, {43'd0, 1'b1, 4'd2, 16'h1234});
        chk("t3_killed", {62'd0, em_reg_write, mem_req}, 64'd0);
        // Register 0 is never written
        cyc(1, 1, 0, 0, 0, 4'd0, 16'h0077, 16'd0, 0, 1);
        chk("t4_em", {63'd0, em_reg_write}, 64'd0);
        idle(1'b1);
        chk("t4_mw", {63'd0, mw_reg_write}, 64'd0);
        // Timeout on a store held off for 16 cycles
        cyc(1, 0, 0, 0, 1, 4'd0, 16'h0100, 16'hBEEF, 0, 0);
        repeat (MW) idle(1'b0);
        chk("t5_pre", {63'd0, mem_timeout}, 64'd0);
        idle(1'b0);
        chk("t5_rise", {63'd0, mem_timeout}, 64'd1);
        idle(1'b1);
        chk("t5_hold", {62'd0, mem_timeout, stall_out}, 64'd2);
        repeat (3) idle(1'b1);
        chk("t5_hold2", {63'd0, mem_timeout}, 64'd1);
        rst_n = 1'b0;
        idle(1'b1);
        chk("t5_clr", {63'd0, mem_timeout}, 64'd0);
        rst_n = 1'b1;
        // Reset in the middle of a stall abandons the request
        cyc(1, 1, 1, 1, 0, 4'd6, 16'h0080, 16'd0, 0, 1);
        idle(1'b0);
        rst_n = 1'b0;
        idle(1'b0);
        chk_zero("t6");
        rst_n = 1'b1;
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            op  = int'($urandom_range(0, 3));
            v   = $urandom_range(0, 3) != 0;
            rw  = $urandom_range(0, 1) == 1;
            mr  = op == 2;
            mw  = op == 3;
            m2r = mr | ($urandom_range(0, 7) == 0);
            fl  = $urandom_range(0, 9) == 0;
            rdy = $urandom_range(0, 9) < 6;
            rst_n = $urandom_range(0, 99) != 0;
            cyc(v, rw, m2r, mr, mw, 4'($urandom), 16'($urandom), 16'($urandom), fl, rdy);
            rst_n = 1'b1;
        end
        repeat (6) idle(1'b1);
        chk("drain_wb", 64'(wq.size()), 64'd0);
        chk("drain_mem", 64'(mq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
